// File: rtl/bram_port_arbiter.sv
// Arbiter sharing one simple dual-port BRAM: round-robin tagged read port, fixed-priority write port.
// Optional conflict statistics counter enabled by defining BRAM_ARB_STATS_EN.
module bram_port_arbiter #(
   parameter int unsigned NUM_RD = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned IDW   = $clog2(NUM_RD)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD-1:0]    rd_req,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD-1:0]    rd_gnt,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [DATA_W-1:0]    rsp_data,
   input  logic                 ld_wr_en,
   input  logic [AW-1:0]        ld_addr,
   input  logic [DATA_W-1:0]    ld_din,
   output logic                 ld_ack,
   input  logic                 pe_wr_en,
   input  logic [AW-1:0]        pe_addr,
   input  logic [DATA_W-1:0]    pe_din,
   output logic                 pe_ack,
   output logic                 bram_we,
   output logic [AW-1:0]        bram_addrin,
   output logic [DATA_W-1:0]    bram_din,
   output logic [AW-1:0]        bram_addrout,
   input  logic [DATA_W-1:0]    bram_dout,
   output logic [15:0]          conflict_cnt
);

   logic [IDW-1:0]    r_ptr;
   logic              r_s1_vld;
   logic [IDW-1:0]    r_s1_id;
   logic              r_rsp_valid;
   logic [IDW-1:0]    r_rsp_id;
   logic [DATA_W-1:0] r_rsp_data;

   logic [NUM_RD-1:0] w_gnt;
   logic [IDW-1:0]    w_gnt_idx;
   logic              w_gnt_any;
   logic [AW-1:0]     w_rd_addr;

   // Round-robin search starting just after the last winner; no grants while in reset
   always_comb begin
      int unsigned v_idx;
      v_idx     = 0;
      w_gnt     = '0;
      w_gnt_idx = '0;
      w_gnt_any = 1'b0;
      for (int unsigned k = 1; k <= NUM_RD; k++) begin
         v_idx = (32'(r_ptr) + k) % NUM_RD;
         if (!rst && !w_gnt_any && rd_req[IDW'(v_idx)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = IDW'(v_idx);
         end
      end
      if (w_gnt_any) begin
         w_gnt[w_gnt_idx] = 1'b1;
      end
   end

   // Read address mux from the one-hot grant
   always_comb begin
      w_rd_addr = '0;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         if (w_gnt[i]) begin
            w_rd_addr = rd_addr[i*AW +: AW];
         end
      end
   end

   // Two-stage tag pipeline matching the BRAM's registered read address
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= IDW'(NUM_RD - 1);
         r_s1_vld    <= 1'b0;
         r_s1_id     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else begin
         if (w_gnt_any) begin
            r_ptr <= w_gnt_idx;
         end
         r_s1_vld    <= w_gnt_any;
         r_s1_id     <= w_gnt_idx;
         r_rsp_valid <= r_s1_vld;
         if (r_s1_vld) begin
            r_rsp_id   <= r_s1_id;
            r_rsp_data <= bram_dout;
         end
      end
   end

   assign rd_gnt       = w_gnt;
   assign bram_addrout = w_rd_addr;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_id       = r_rsp_id;
   assign rsp_data     = r_rsp_data;

   // Loader always beats PE update on the write port
   always_comb begin
      ld_ack      = 1'b0;
      pe_ack      = 1'b0;
      bram_we     = 1'b0;
      bram_addrin = '0;
      bram_din    = '0;
      if (ld_wr_en) begin
         ld_ack      = 1'b1;
         bram_we     = 1'b1;
         bram_addrin = ld_addr;
         bram_din    = ld_din;
      end else if (pe_wr_en) begin
         pe_ack      = 1'b1;
         bram_we     = 1'b1;
         bram_addrin = pe_addr;
         bram_din    = pe_din;
      end
   end

`ifdef BRAM_ARB_STATS_EN
   logic [15:0] r_conflict_cnt;
   logic        w_conflict;

   assign w_conflict = (|(rd_req & (rd_req - NUM_RD'(1)))) || (ld_wr_en && pe_wr_en);

   // Saturating count of cycles with contention on either port
   always_ff @(posedge clk) begin
      if (rst) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign conflict_cnt = r_conflict_cnt;
`else
   assign conflict_cnt = '0;
`endif

endmodule
